// File: rtl/dump_sequencer.sv
// Purpose : replays one channel capture RAM, oldest sample first, byte by byte into UART_tx.
// Latency : dump_req -> first trmt 4 clks; tx_done -> next trmt 4 clks.
// Backpressure: one byte in flight; the next RAM read waits for tx_done of the current byte.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   dump_req, dump_ch          start pulse and channel (1..5) from the command processor
//   trace_end                  address of the newest sample; the dump ends on it
//   ram_addr, ram_rd_en,       read port to the channel RAMs (data one cycle after rd_en),
//   ch_sel, ram_rdata          ch_sel steers which RAM drives ram_rdata
//   tx_data, trmt, tx_done     byte handshake with UART_tx
//   dumping, dump_done, bad_ch status to the command processor
module dump_sequencer #(
    parameter int ENTRIES = 384,
    parameter int ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_req,
    input  logic [2:0]        dump_ch,
    input  logic [ADDR_W-1:0] trace_end,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    output logic [2:0]        ch_sel,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tx_data,
    output logic              trmt,
    input  logic              tx_done,
    output logic              dumping,
    output logic              dump_done,
    output logic              bad_ch
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

    typedef enum logic [2:0] {IDLE, RD, LAT, SEND, WAIT_TX, FIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] count, count_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [2:0]        ch_sel_nxt;
    logic [7:0]        tx_data_nxt;
    logic              rd_en_nxt, trmt_nxt, dumping_nxt, done_nxt, bad_nxt;
    logic              ch_ok;

    assign ch_ok = (dump_ch != 3'd0) && (dump_ch <= 3'd5);

    // All outputs are registered; the next-state logic computes their next values,
    // so each strobe is high during the state it is named after (rd_en in RD, trmt
    // in the first WAIT_TX cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            ram_addr  <= '0;
            ram_rd_en <= 1'b0;
            ch_sel    <= 3'd0;
            tx_data   <= 8'd0;
            trmt      <= 1'b0;
            dumping   <= 1'b0;
            dump_done <= 1'b0;
            bad_ch    <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_rd_en <= rd_en_nxt;
            ch_sel    <= ch_sel_nxt;
            tx_data   <= tx_data_nxt;
            trmt      <= trmt_nxt;
            dumping   <= dumping_nxt;
            dump_done <= done_nxt;
            bad_ch    <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        ram_addr_nxt = ram_addr;
        ch_sel_nxt   = ch_sel;
        tx_data_nxt  = tx_data;
        dumping_nxt  = dumping;
        rd_en_nxt    = 1'b0;
        trmt_nxt     = 1'b0;
        done_nxt     = 1'b0;
        bad_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (dump_req) begin
                    if (ch_ok) begin
                        ch_sel_nxt   = dump_ch;
                        // Oldest sample sits just after the newest one; an out-of-range
                        // trace_end also restarts at 0 so no address >= ENTRIES is driven.
                        ram_addr_nxt = (trace_end >= LAST) ? '0 : trace_end + ADDR_W'(1);
                        count_nxt    = '0;
                        dumping_nxt  = 1'b1;
                        rd_en_nxt    = 1'b1;
                        state_nxt    = RD;
                    end else begin
                        bad_nxt = 1'b1;
                    end
                end
            end
            RD: begin
                state_nxt = LAT;
            end
            LAT: begin
                tx_data_nxt = ram_rdata;
                state_nxt   = SEND;
            end
            SEND: begin
                trmt_nxt  = 1'b1;
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    if (count == LAST) begin
                        state_nxt = FIN;
                    end else begin
                        count_nxt    = count + ADDR_W'(1);
                        ram_addr_nxt = (ram_addr >= LAST) ? '0 : ram_addr + ADDR_W'(1);
                        rd_en_nxt    = 1'b1;
                        state_nxt    = RD;
                    end
                end
            end
            FIN: begin
                done_nxt    = 1'b1;
                dumping_nxt = 1'b0;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dump_sequencer.sv
// Purpose : self-checking bench for dump_sequencer with a RAM model, UART model and scoreboard.
// Latency : checks 4 clks from dump_req / tx_done to trmt.
// Backpressure: UART model answers tx_done 10 clks after each trmt.
module tb_dump_sequencer;

    localparam int ENTRIES = 384;
    localparam int ADDR_W  = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dump_req;
    logic [2:0]        dump_ch;
    logic [ADDR_W-1:0] trace_end;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic [2:0]        ch_sel;
    logic [7:0]        ram_rdata = 8'd0;
    logic [7:0]        tx_data;
    logic              trmt;
    logic              tx_done;
    logic              dumping;
    logic              dump_done;
    logic              bad_ch;

    dump_sequencer #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dump_req  (dump_req),
        .dump_ch   (dump_ch),
        .trace_end (trace_end),
        .ram_addr  (ram_addr),
        .ram_rd_en (ram_rd_en),
        .ch_sel    (ch_sel),
        .ram_rdata (ram_rdata),
        .tx_data   (tx_data),
        .trmt      (trmt),
        .tx_done   (tx_done),
        .dumping   (dumping),
        .dump_done (dump_done),
        .bad_ch    (bad_ch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Channel 3 holds its own address low byte; other channels get a distinct pattern
    // so a wrong ch_sel shows up as wrong data.
    function automatic int ram_val(input logic [2:0] ch, input logic [8:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        if (ch == 3'd3) return int'(lo);
        return int'(lo ^ {ch, 5'b0} ^ {7'b0, a[8]});
    endfunction

    always @(posedge clk) begin
        if (ram_rd_en) ram_rdata <= 8'(ram_val(ch_sel, ram_addr));
    end

    // Scoreboard state
    int exp_addr[$];
    int exp_data[$];
    int exp_ch        = 0;
    int last_evt_cyc  = 0;
    int trmt_cnt      = 0;
    int done_cnt      = 0;
    int bad_cnt       = 0;
    int rd_cnt        = 0;
    int first_rd_addr = -1;
    int last_rd_addr  = -1;
    bit first_pend    = 1'b0;

    // Monitor: compares every read strobe and every trmt against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_rd_en) begin
                rd_cnt++;
                if (first_pend) begin
                    first_rd_addr = int'(ram_addr);
                    first_pend    = 1'b0;
                end
                last_rd_addr = int'(ram_addr);
                check("ch_sel", int'(ch_sel), exp_ch);
                check("rd_expected", int'(exp_addr.size() > 0), 1);
                if (exp_addr.size() > 0) check("ram_addr", int'(ram_addr), exp_addr.pop_front());
            end
            if (trmt) begin
                trmt_cnt++;
                check("trmt_latency", cyc - last_evt_cyc, 4);
                check("trmt_expected", int'(exp_data.size() > 0), 1);
                if (exp_data.size() > 0) check("tx_data", int'(tx_data), exp_data.pop_front());
            end
            if (dump_done) done_cnt++;
            if (bad_ch) bad_cnt++;
        end
    end

    // UART_tx model: tx_done 10 clks after trmt, tx_data must hold meanwhile; reset aborts.
    initial begin
        int  held;
        bit  abort;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && trmt) begin
                held  = int'(tx_data);
                abort = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        abort = 1'b1;
                        break;
                    end
                    check("tx_data_hold", int'(tx_data), held);
                end
                if (!abort) begin
                    tx_done      = 1'b1;
                    last_evt_cyc = cyc;
                    @(negedge clk);
                    tx_done = 1'b0;
                end
            end
        end
    end

    task automatic prime(input int ch, input int te);
        int a;
        trace_end = 9'(te);
        exp_ch    = ch;
        exp_addr.delete();
        exp_data.delete();
        for (int k = 0; k < ENTRIES; k++) begin
            a = (te + 1 + k) % ENTRIES;
            exp_addr.push_back(a);
            exp_data.push_back(ram_val(3'(ch), 9'(a)));
        end
        first_pend = 1'b1;
    endtask

    task automatic pulse_req(input int ch);
        dump_ch      = 3'(ch);
        dump_req     = 1'b1;
        last_evt_cyc = cyc;
        @(negedge clk);
        dump_req = 1'b0;
    endtask

    task automatic run_dump(input int ch, input int te, input int first, input bit mid_req);
        int t_trmt, t_done, t_bad;
        bit fired;
        fired  = 1'b0;
        prime(ch, te);
        t_trmt = trmt_cnt;
        t_done = done_cnt;
        t_bad  = bad_cnt;
        pulse_req(ch);
        check("dumping_set", int'(dumping), 1);
        for (int i = 0; i < 8000; i++) begin
            if (done_cnt != t_done) break;
            @(negedge clk);
            if (mid_req && !fired && (trmt_cnt - t_trmt >= 10)) begin
                dump_ch  = 3'd4;
                dump_req = 1'b1;
                @(negedge clk);
                dump_req = 1'b0;
                fired    = 1'b1;
                check("mid_req_dumping", int'(dumping), 1);
            end
        end
        check("dump_done_one_cycle", int'(dump_done), 0);
        repeat (5) @(negedge clk);
        check("dump_done_count", done_cnt - t_done, 1);
        check("trmt_count", trmt_cnt - t_trmt, ENTRIES);
        check("first_addr", first_rd_addr, first);
        check("last_addr", last_rd_addr, te);
        check("dumping_clear", int'(dumping), 0);
        check("queue_drained", exp_addr.size() + exp_data.size(), 0);
        check("no_bad_ch", bad_cnt - t_bad, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_ram_rd_en", int'(ram_rd_en), 0);
        check("rst_ch_sel", int'(ch_sel), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_trmt", int'(trmt), 0);
        check("rst_dumping", int'(dumping), 0);
        check("rst_dump_done", int'(dump_done), 0);
        check("rst_bad_ch", int'(bad_ch), 0);
    endtask

    initial begin
        int bads[3];
        int rd0, t0;
        bit busy;
        bads      = '{0, 6, 7};
        rst_n     = 1'b0;
        dump_req  = 1'b0;
        dump_ch   = 3'd0;
        trace_end = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Invalid channels
        foreach (bads[i]) begin
            rd0 = rd_cnt;
            t0  = trmt_cnt;
            pulse_req(bads[i]);
            check("bad_ch_pulse", int'(bad_ch), 1);
            check("bad_ch_dumping", int'(dumping), 0);
            @(negedge clk);
            check("bad_ch_one_cycle", int'(bad_ch), 0);
            repeat (8) @(negedge clk);
            check("bad_ch_no_read", rd_cnt - rd0, 0);
            check("bad_ch_no_trmt", trmt_cnt - t0, 0);
        end

        run_dump(2, 100, 101, 1'b0);
        run_dump(5, 383, 0, 1'b0);
        run_dump(1, 0, 1, 1'b1);     // includes an ignored ch4 request mid-dump
        run_dump(3, 200, 201, 1'b0); // tx_data = address low byte

        // Reset after the 50th byte's trmt
        prime(2, 100);
        t0 = trmt_cnt;
        pulse_req(2);
        for (int i = 0; i < 2000; i++) begin
            if (trmt_cnt - t0 >= 50) break;
            @(negedge clk);
        end
        check("reached_byte_50", trmt_cnt - t0, 50);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_addr.delete();
        exp_data.delete();
        busy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            busy = busy | trmt | ram_rd_en;
        end
        check("quiet_in_reset", int'(busy), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", int'(dumping), 0);
        run_dump(2, 100, 101, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
